// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - CPU/external bus arbiter with pipeline drain, burst limit and CPU cooldown
// Optional statistics counters are built when BUS_ARBITER_STATS_EN is defined.
module bus_arbiter #(
    parameter int PIPE_DEPTH = 2,
    parameter int MAX_BURST  = 16,
    parameter int MIN_CPU    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        dma_req,
    input  logic        dma_done,
    input  logic        fetch_suppress_in,
    output logic        bus_request,
    output logic        dma_grant,
    output logic        bus_owner,
    output logic [7:0]  burst_count,
    output logic        forced_release,
    output logic [15:0] grant_total,
    output logic [15:0] preempt_total
);

    typedef enum logic [1:0] {
        S_CPU     = 2'd0,
        S_DRAIN   = 2'd1,
        S_GRANT   = 2'd2,
        S_RECOVER = 2'd3
    } state_t;

    localparam logic [7:0] DRAIN_LAST = 8'(PIPE_DEPTH - 1);
    localparam logic [7:0] BURST_LAST = 8'(MAX_BURST - 1);
    localparam logic [7:0] COOL_LOAD  = 8'(MIN_CPU);

    state_t     state;
    logic [7:0] drain_cnt;
    logic [7:0] cooldown;

    logic grant_entry;
    logic grant_exit;
    logic force_exit;

    // Strobes for the edges that enter and leave a grant; shared by the FSM and the statistics
    always_comb begin
        grant_entry = (state == S_DRAIN) && dma_req && !fetch_suppress_in
                      && (drain_cnt == DRAIN_LAST);
        grant_exit  = (state == S_GRANT)
                      && (dma_done || !dma_req || (burst_count == BURST_LAST));
        force_exit  = (state == S_GRANT) && dma_req && !dma_done
                      && (burst_count == BURST_LAST);
    end

    // Arbitration FSM; every output is registered alongside the state it belongs to
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= S_CPU;
            drain_cnt      <= '0;
            cooldown       <= '0;
            bus_request    <= 1'b1;
            dma_grant      <= 1'b0;
            bus_owner      <= 1'b0;
            burst_count    <= '0;
            forced_release <= 1'b0;
        end else begin
            forced_release <= 1'b0;
            case (state)
                S_CPU: begin
                    bus_request <= 1'b1;
                    dma_grant   <= 1'b0;
                    bus_owner   <= 1'b0;
                    burst_count <= '0;
                    if (cooldown != 8'd0) begin
                        cooldown <= cooldown - 8'd1;
                    end
                    if (dma_req && (cooldown == 8'd0)) begin
                        state       <= S_DRAIN;
                        drain_cnt   <= '0;
                        bus_request <= 1'b0;
                    end
                end
                S_DRAIN: begin
                    if (!dma_req) begin
                        // Requester gave up before the grant: hand fetch straight back, no cooldown
                        state       <= S_CPU;
                        bus_request <= 1'b1;
                    end else if (fetch_suppress_in) begin
                        drain_cnt <= '0;
                    end else if (grant_entry) begin
                        state       <= S_GRANT;
                        dma_grant   <= 1'b1;
                        bus_owner   <= 1'b1;
                        burst_count <= '0;
                    end else begin
                        drain_cnt <= drain_cnt + 8'd1;
                    end
                end
                S_GRANT: begin
                    if (grant_exit) begin
                        state          <= S_RECOVER;
                        dma_grant      <= 1'b0;
                        bus_owner      <= 1'b0;
                        forced_release <= force_exit;
                    end else begin
                        burst_count <= burst_count + 8'd1;
                    end
                end
                S_RECOVER: begin
                    // One turnaround cycle, then the CPU is guaranteed its minimum window
                    state       <= S_CPU;
                    bus_request <= 1'b1;
                    cooldown    <= COOL_LOAD;
                    burst_count <= '0;
                end
                default: begin
                    state       <= S_CPU;
                    bus_request <= 1'b1;
                    dma_grant   <= 1'b0;
                    bus_owner   <= 1'b0;
                end
            endcase
        end
    end

`ifdef BUS_ARBITER_STATS_EN
    // Saturating counts of grants issued and grants cut short by the burst limit
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            grant_total   <= '0;
            preempt_total <= '0;
        end else begin
            if (grant_entry && (grant_total != 16'hFFFF)) begin
                grant_total <= grant_total + 16'd1;
            end
            if (force_exit && (preempt_total != 16'hFFFF)) begin
                preempt_total <= preempt_total + 16'd1;
            end
        end
    end
`else
    assign grant_total   = '0;
    assign preempt_total = '0;
`endif

endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - self-checking bench for bus_arbiter
module tb_bus_arbiter;

    localparam int PIPE_DEPTH = 2;
    localparam int MAX_BURST  = 16;
    localparam int MIN_CPU    = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        dma_req = 1'b0;
    logic        dma_done = 1'b0;
    logic        fetch_suppress_in = 1'b0;
    logic        bus_request;
    logic        dma_grant;
    logic        bus_owner;
    logic [7:0]  burst_count;
    logic        forced_release;
    logic [15:0] grant_total;
    logic [15:0] preempt_total;

    int checks = 0;
    int failures = 0;

    bus_arbiter #(
        .PIPE_DEPTH(PIPE_DEPTH),
        .MAX_BURST (MAX_BURST),
        .MIN_CPU   (MIN_CPU)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .dma_req          (dma_req),
        .dma_done         (dma_done),
        .fetch_suppress_in(fetch_suppress_in),
        .bus_request      (bus_request),
        .dma_grant        (dma_grant),
        .bus_owner        (bus_owner),
        .burst_count      (burst_count),
        .forced_release   (forced_release),
        .grant_total      (grant_total),
        .preempt_total    (preempt_total)
    );

    always #5 clk = ~clk;

    // Reference model: who holds the bus, how many clear drain cycles have been seen,
    // how old the grant is, and how many CPU cycles of protection remain.
    bit   m_draining, m_granted, m_turnaround;
    int   m_clear_run, m_age, m_cool;
    logic e_breq, e_grant, e_owner, e_forced;
    int   e_bc, e_gt, e_pt;

    task automatic model_edge();
        if (!rst_n) begin
            m_draining = 0; m_granted = 0; m_turnaround = 0;
            m_clear_run = 0; m_age = 0; m_cool = 0;
            e_breq = 1; e_grant = 0; e_owner = 0; e_forced = 0;
            e_bc = 0; e_gt = 0; e_pt = 0;
            return;
        end
        e_forced = 0;
        if (m_turnaround) begin
            m_turnaround = 0;
            m_cool = MIN_CPU;
            e_breq = 1;
            e_bc = 0;
        end else if (m_granted) begin
            if (dma_done || !dma_req || m_age == MAX_BURST - 1) begin
                e_forced = dma_req && !dma_done && (m_age == MAX_BURST - 1);
                if (e_forced && e_pt < 65535) e_pt++;
                m_granted = 0;
                m_turnaround = 1;
                e_grant = 0;
                e_owner = 0;
            end else begin
                m_age++;
                e_bc = m_age;
            end
        end else if (m_draining) begin
            if (!dma_req) begin
                m_draining = 0;
                e_breq = 1;
            end else if (fetch_suppress_in) begin
                m_clear_run = 0;
            end else begin
                m_clear_run++;
                if (m_clear_run == PIPE_DEPTH) begin
                    m_draining = 0;
                    m_granted = 1;
                    m_age = 0;
                    e_bc = 0;
                    e_grant = 1;
                    e_owner = 1;
                    if (e_gt < 65535) e_gt++;
                end
            end
        end else begin
            if (dma_req && m_cool == 0) begin
                m_draining = 1;
                m_clear_run = 0;
                e_breq = 0;
            end else if (m_cool > 0) begin
                m_cool--;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic compare_all();
        chk("bus_request", 32'(bus_request), 32'(e_breq));
        chk("dma_grant", 32'(dma_grant), 32'(e_grant));
        chk("bus_owner", 32'(bus_owner), 32'(e_owner));
        chk("forced_release", 32'(forced_release), 32'(e_forced));
        if (e_grant) chk("burst_count", 32'(burst_count), 32'(e_bc));
        if (e_breq) chk("burst_count_cpu", 32'(burst_count), 32'd0);
`ifdef BUS_ARBITER_STATS_EN
        chk("grant_total", 32'(grant_total), 32'(e_gt));
        chk("preempt_total", 32'(preempt_total), 32'(e_pt));
`else
        chk("grant_total", 32'(grant_total), 32'd0);
        chk("preempt_total", 32'(preempt_total), 32'd0);
`endif
    endtask

    task automatic tick(input logic r, input logic d, input logic s);
        dma_req = r;
        dma_done = d;
        fetch_suppress_in = s;
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b0);
    endtask

    // Hold dma_req and return the number of edges until dma_grant is seen
    task automatic wait_grant(output int n);
        n = 0;
        while (!dma_grant && n < 20) begin
            tick(1'b1, 1'b0, 1'b0);
            n++;
        end
    endtask

    initial begin
        int n, len, run, saved_gt;
        logic req;

        // Reset held with a pending request
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 1'b0);
        rst_n = 1'b1;
        wait_grant(n);
        chk("reset_release_latency", 32'(n), 32'd3);
        tick(1'b0, 1'b0, 1'b0);
        idle(6);

        // Normal grant ended by dma_done in grant cycle 4
        wait_grant(n);
        chk("req_to_grant_latency", 32'(n), 32'd3);
        len = 1;
        for (int i = 0; i < 4; i++) begin
            tick(1'b1, 1'b0, 1'b0);
            if (dma_grant) len++;
        end
        tick(1'b1, 1'b1, 1'b0);
        chk("done_grant_length", 32'(len), 32'd5);
        chk("recover_no_grant", 32'(dma_grant), 32'd0);
        chk("recover_breq", 32'(bus_request), 32'd0);
        run = 0;
        n = 0;
        tick(1'b1, 1'b0, 1'b0);
        while (bus_request && n < 20) begin
            run++;
            n++;
            tick(1'b1, 1'b0, 1'b0);
        end
        chk("cpu_window_ge_min", 32'(run >= MIN_CPU), 32'd1);
        tick(1'b0, 1'b0, 1'b0);
        idle(6);

        // Suppressed drain, with a suppress pulse restarting the clear count
        tick(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) tick(1'b1, 1'b0, 1'b1);
        chk("suppress_hold", 32'(dma_grant), 32'd0);
        tick(1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b1);
        chk("suppress_restart", 32'(dma_grant), 32'd0);
        tick(1'b1, 1'b0, 1'b0);
        chk("one_clear_not_enough", 32'(dma_grant), 32'd0);
        tick(1'b1, 1'b0, 1'b0);
        chk("two_clear_grant", 32'(dma_grant), 32'd1);
        tick(1'b0, 1'b0, 1'b0);
        idle(6);

        // Two forced releases back to back with dma_req held
        wait_grant(n);
        for (int g = 0; g < 2; g++) begin
            len = 1;
            n = 0;
            while (dma_grant && n < 40) begin
                tick(1'b1, 1'b0, 1'b0);
                if (dma_grant) len++;
                n++;
            end
            chk("forced_grant_length", 32'(len), 32'(MAX_BURST));
            chk("forced_pulse", 32'(forced_release), 32'd1);
            if (g == 0) begin
                n = 0;
                while (!dma_grant && n < 20) begin
                    tick(1'b1, 1'b0, 1'b0);
                    n++;
                end
                chk("regrant_gap", 32'(n), 32'(1 + MIN_CPU + 1 + PIPE_DEPTH));
            end
        end
        tick(1'b0, 1'b0, 1'b0);
        chk("forced_pulse_single", 32'(forced_release), 32'd0);
`ifdef BUS_ARBITER_STATS_EN
        chk("stats_grants", 32'(grant_total), 32'd5);
        chk("stats_preempts", 32'(preempt_total), 32'd2);
`else
        chk("stats_grants_off", 32'(grant_total), 32'd0);
        chk("stats_preempts_off", 32'(preempt_total), 32'd0);
`endif
        idle(6);

        // Request withdrawn during drain
        saved_gt = int'(grant_total);
        tick(1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        chk("abort_breq", 32'(bus_request), 32'd1);
        chk("abort_no_grant", 32'(dma_grant), 32'd0);
        chk("abort_gt_unchanged", 32'(grant_total), 32'(saved_gt));
        idle(3);

        // Randomized traffic against the model
        req = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 15) == 0) req = ~req;
            tick(req, ($urandom_range(0, 19) == 0), ($urandom_range(0, 3) == 0));
        end
        idle(8);

        // Reset in the middle of a grant
        wait_grant(n);
        tick(1'b1, 1'b0, 1'b0);
        rst_n = 1'b0;
        tick(1'b1, 1'b0, 1'b0);
        chk("reset_mid_grant", 32'(dma_grant), 32'd0);
        chk("reset_mid_breq", 32'(bus_request), 32'd1);
        rst_n = 1'b1;
        tick(1'b0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Shares the CPU memory bus between the pipeline fetch path and one external requester (DMA/front-panel loader).
- Drives pipeline stage 1's bus_request line so that stage 1 injects NOP (0x00) instructions while the bus is away.
- Waits for the pipeline to drain before granting the bus, bounds the length of an external burst, and guarantees the CPU a minimum run window between grants.

Parameters:
- PIPE_DEPTH, 2, number of consecutive non-suppressed drain cycles needed before a grant.
- MAX_BURST, 16, maximum cycles dma_grant stays high before a forced release (2..255).
- MIN_CPU, 2, cycles the CPU keeps the bus after a release before the next grant (0..255).

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  synchronous active-low reset
- dma_req  in  1  external request; held high for as long as the bus is wanted
- dma_done  in  1  one-cycle pulse; external master finished, sampled only in GRANT
- fetch_suppress_in  in  1  stage-1 controls bit 15; high = multi-cycle op in progress, not a safe boundary
- bus_request  out  1  1 = CPU fetch normal; 0 = bus being taken or held, stage 1 forces NOPs
- dma_grant  out  1  external master may drive the bus
- bus_owner  out  1  address/data mux select; 0 = CPU, 1 = external
- burst_count  out  8  cycles spent in the current grant, 0-based
- forced_release  out  1  one-cycle pulse when a grant ends on MAX_BURST
- grant_total  out  16  statistics (see Optional Feature)
- preempt_total  out  16  statistics (see Optional Feature)

Behaviour:
- All outputs are registered.
- Reset (rst_n=0 at edge) values:
  - state=CPU, bus_request=1, dma_grant=0, bus_owner=0
  - burst_count=0, forced_release=0, counters=0
  - drain and cooldown counters cleared
- Reset mid-grant drops dma_grant on the next edge, with no RECOVER cycle.
- States: CPU, DRAIN, GRANT, RECOVER.
- CPU:
  - Outputs: bus_request=1, dma_grant=0, bus_owner=0.
  - The cooldown counter decrements to 0 while in CPU.
  - If dma_req=1 and cooldown=0, go to DRAIN and clear the drain counter.
- DRAIN:
  - Outputs: bus_request=0, dma_grant=0.
  - Drain counter: +1 when fetch_suppress_in=0; reset to 0 when fetch_suppress_in=1.
  - When drain counter reaches PIPE_DEPTH-1 with fetch_suppress_in=0, go to GRANT.
  - If dma_req=0 at any DRAIN edge, abort to CPU: bus_request=1 next cycle, cooldown not loaded.
- GRANT:
  - Outputs: dma_grant=1, bus_owner=1, bus_request=0.
  - burst_count is 0 in the first grant cycle and increments each cycle after that.
  - Exit to RECOVER on the first of: dma_done=1, dma_req=0, or burst_count=MAX_BURST-1.
  - If the exit is on MAX_BURST with neither dma_done nor a dma_req drop, pulse forced_release for 1 cycle.
  - If dma_done and the limit coincide, the exit counts as normal (no pulse).
  - Grant length is therefore 1..MAX_BURST cycles.
- RECOVER:
  - Exactly 1 cycle: dma_grant=0, bus_owner=0, bus_request=0 (bus turnaround).
  - Then go to CPU with cooldown=MIN_CPU and burst_count reset to 0.
- Latency, dma_req rising to dma_grant, with fetch_suppress_in=0 throughout: 1 (CPU→DRAIN) + PIPE_DEPTH cycles = 3 edges at defaults.
- A dma_req held high continuously re-requests after cooldown expires; there is no starvation of either side.
- dma_done outside GRANT is ignored.

Optional Feature:
- Macro: BUS_ARBITER_STATS_EN.
- Defined:
  - grant_total increments on every GRANT entry.
  - preempt_total increments on every forced_release.
  - Both are 16-bit, saturate at 0xFFFF (no wrap), and clear on reset.
- Undefined: both ports are tied to 0 and no counter registers are built.

Test Plan:
- Reset held 3 cycles with dma_req=1 -> bus_request=1, dma_grant=0, bus_owner=0 throughout; first grant appears 3 edges after release of rst_n.
- dma_req rises, fetch_suppress_in=0, dma_done pulses in grant cycle 4 -> bus_request=0 from edge 1, dma_grant high for exactly 5 cycles, one RECOVER cycle, then bus_request=1 for ≥2 cycles before any new DRAIN.
- fetch_suppress_in=1 for 4 DRAIN cycles, then 0 -> grant delayed until 2 consecutive clear cycles; a suppress pulse after 1 clear cycle restarts the count.
- dma_req held high, no dma_done, MAX_BURST=16 -> dma_grant high exactly 16 cycles, burst_count 0..15, forced_release single pulse, re-grant after RECOVER + 2 cooldown + drain.
- dma_req dropped during DRAIN -> bus_request back to 1 the next cycle, dma_grant never asserted, grant_total unchanged.
- With BUS_ARBITER_STATS_EN, 3 normal grants + 2 forced -> grant_total=5, preempt_total=2; without the macro both read 0.
